// File: rtl/btb_pred_if.sv
// btb_pred_if -- fetch / resolve / redirect bundle between the pipeline and the BTB predictor.
//   master : pipeline side. Drives the fetch slot (f_valid, f_pc) and the resolve-stage
//            outcome (r_is_branch, r_taken, r_target). Receives next_pc, redirect,
//            nop_en and miss_cnt.
//   slave  : predictor side (btb_pred).
interface btb_pred_if #(
  parameter int DATA_W = 16
);
  logic              f_valid;
  logic [DATA_W-1:0] f_pc;
  logic              r_is_branch;
  logic              r_taken;
  logic [DATA_W-1:0] r_target;
  logic [DATA_W-1:0] next_pc;
  logic              redirect;
  logic              nop_en;
  logic [DATA_W-1:0] miss_cnt;

  modport master (
    output f_valid, f_pc, r_is_branch, r_taken, r_target,
    input  next_pc, redirect, nop_en, miss_cnt
  );

  modport slave (
    input  f_valid, f_pc, r_is_branch, r_taken, r_target,
    output next_pc, redirect, nop_en, miss_cnt
  );
endinterface

// File: rtl/btb_pred.sv
// btb_pred -- direct-mapped branch target buffer with 2-bit counters, a resolve
// delay line, mispredict redirect/flush and a saturating mispredict counter.
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : btb_pred_if.slave
//            f_valid/f_pc                  fetch slot
//            r_is_branch/r_taken/r_target  outcome of the instruction at resolve
//            next_pc   PC to fetch next cycle
//            redirect  mispredict detected this cycle
//            nop_en    kill in-flight wrong-path slots
//            miss_cnt  saturating mispredict count
module btb_pred #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 6,
  parameter int RES_DLY = 2
) (
  input  logic        clk,
  input  logic        reset,
  btb_pred_if.slave   bus
);

  localparam int DEPTH = 1 << IDX_W;
  // Wide enough to hold RES_DLY-1.
  localparam int FL_W  = (RES_DLY > 1) ? $clog2(RES_DLY) : 1;
  localparam logic [DATA_W-1:0] PC_ONE = DATA_W'(1);

  // One in-flight fetch slot: what was predicted, so resolve can judge it.
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] pc;
    logic              pt;
    logic [DATA_W-1:0] ptgt;
    logic              hit;
  } stage_t;

  // Table storage.
  logic [DEPTH-1:0]             tv_q,  tv_d;
  logic [DEPTH-1:0][1:0]        ctr_q, ctr_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [DEPTH-1:0][DATA_W-1:0] tgt_q, tgt_d;

  stage_t            dl_q [RES_DLY];
  stage_t            dl_d [RES_DLY];
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [DATA_W-1:0] miss_q,  miss_d;

  // Fetch-side lookup.
  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic              f_hit;
  logic              f_pt;
  logic [DATA_W-1:0] f_tgt;

  // Resolve side.
  stage_t            res;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              mispredict;
  logic              nop_en;
  logic [DATA_W-1:0] next_pc;

  assign f_idx = bus.f_pc[IDX_W-1:0];
  assign f_tag = bus.f_pc[IDX_W+TAG_W-1:IDX_W];
  assign f_hit = tv_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pt  = bus.f_valid && f_hit && ctr_q[f_idx][1];
  assign f_tgt = tgt_q[f_idx];

  assign res   = dl_q[RES_DLY-1];
  assign r_idx = res.pc[IDX_W-1:0];
  assign r_tag = res.pc[IDX_W+TAG_W-1:IDX_W];

  // Resolve inputs only count when the oldest slot holds a live fetch.
  always_comb begin
    mispredict = 1'b0;
    if (res.v) begin
      if (bus.r_is_branch)
        mispredict = (bus.r_taken != res.pt) ||
                     (bus.r_taken && res.pt && (bus.r_target != res.ptgt));
      else
        mispredict = res.pt;
    end
  end

  assign nop_en = mispredict || (flush_q != '0);

  always_comb begin
    if (mispredict)
      next_pc = bus.r_taken ? bus.r_target : res.pc + PC_ONE;
    else if (f_pt)
      next_pc = f_tgt;
    else
      next_pc = bus.f_pc + PC_ONE;
  end

  assign bus.next_pc  = next_pc;
  assign bus.redirect = mispredict;
  assign bus.nop_en   = nop_en;
  assign bus.miss_cnt = miss_q;

  // Delay line, flush counter and miss counter.
  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dl_d[0] = '{v: bus.f_valid && !nop_en, pc: bus.f_pc, pt: f_pt,
                ptgt: f_tgt, hit: f_hit};
    for (int i = 1; i < RES_DLY; i++) dl_d[i] = dl_q[i-1];
    if (mispredict)
      for (int i = 0; i < RES_DLY; i++) dl_d[i].v = 1'b0;

    flush_d = flush_q;
    if (mispredict)           flush_d = FL_W'(RES_DLY - 1);
    else if (flush_q != '0)   flush_d = flush_q - FL_W'(1);

    miss_d = miss_q;
    if (mispredict && (miss_q != '1)) miss_d = miss_q + PC_ONE;
  end

  // Table update from the resolving slot; written at the closing edge, so a
  // same-cycle lookup still reads the old contents.
  always_comb begin
    tv_d  = tv_q;
    ctr_d = ctr_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    if (res.v) begin
      if (bus.r_is_branch) begin
        if (res.hit) begin
          if (bus.r_taken) begin
            ctr_d[r_idx] = (ctr_q[r_idx] == 2'b11) ? 2'b11 : ctr_q[r_idx] + 2'd1;
            tgt_d[r_idx] = bus.r_target;
          end else begin
            ctr_d[r_idx] = (ctr_q[r_idx] == 2'b00) ? 2'b00 : ctr_q[r_idx] - 2'd1;
          end
        end else if (bus.r_taken) begin
          tv_d[r_idx]  = 1'b1;
          tag_d[r_idx] = r_tag;
          ctr_d[r_idx] = 2'b10;
          tgt_d[r_idx] = bus.r_target;
        end
      end else if (res.hit) begin
        // Predictor aliased onto a non-branch: drop the entry.
        tv_d[r_idx] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q    <= '0;
      ctr_q   <= {DEPTH{2'b01}};
      for (int i = 0; i < RES_DLY; i++) dl_q[i] <= '0;
      flush_q <= '0;
      miss_q  <= '0;
    end else begin
      tv_q    <= tv_d;
      ctr_q   <= ctr_d;
      for (int i = 0; i < RES_DLY; i++) dl_q[i] <= dl_d[i];
      flush_q <= flush_d;
      miss_q  <= miss_d;
    end
  end

  // NOTE: tags and targets are plain storage with no reset; the cleared valid
  // bits make their contents unobservable until an entry is allocated.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_btb_pred.sv
// tb_btb_pred -- directed scoreboard bench for btb_pred (DATA_W=16, IDX_W=4,
// TAG_W=6, RES_DLY=2). Each stimulus cycle pushes its hand-computed expected
// outputs; a monitor pops one entry per cycle at the falling edge and compares.
module tb_btb_pred;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  btb_pred_if #(.DATA_W(16)) bif ();

  btb_pred #(.DATA_W(16), .IDX_W(4), .TAG_W(6), .RES_DLY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    string       name;
    logic [15:0] npc;
    logic        rd;
    logic        nop;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h", nm, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whatever is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".next_pc"},  bif.next_pc,          e.npc);
        check({e.name, ".redirect"}, {15'b0, bif.redirect}, {15'b0, e.rd});
        check({e.name, ".nop_en"},   {15'b0, bif.nop_en},   {15'b0, e.nop});
        check({e.name, ".miss_cnt"}, bif.miss_cnt,          e.miss);
      end
    end
  end

  task automatic step(input string nm, input logic fv, input logic [15:0] pc,
                      input logic rb, input logic rt, input logic [15:0] rtg,
                      input logic [15:0] e_npc, input logic e_rd, input logic e_nop,
                      input logic [15:0] e_miss, input logic rst = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    bif.f_valid     = fv;
    bif.f_pc        = pc;
    bif.r_is_branch = rb;
    bif.r_taken     = rt;
    bif.r_target    = rtg;
    e.name = nm; e.npc = e_npc; e.rd = e_rd; e.nop = e_nop; e.miss = e_miss;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic e_nop, input logic [15:0] e_miss,
                      input logic rst = 1'b0);
    step(nm, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, e_nop, e_miss, rst);
  endtask

  task automatic fetch(input string nm, input logic [15:0] pc, input logic [15:0] e_npc,
                       input logic e_nop, input logic [15:0] e_miss);
    step(nm, 1'b1, pc, 1'b0, 1'b0, 16'h0000, e_npc, 1'b0, e_nop, e_miss);
  endtask

  initial begin
    bif.f_valid = 1'b0; bif.f_pc = '0;
    bif.r_is_branch = 1'b0; bif.r_taken = 1'b0; bif.r_target = '0;
    repeat (3) @(posedge clk);

    // Post-reset state and PC wrap.
    step("rst_idle", 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h1235, 1'b0, 1'b0, 16'd0);
    step("pc_wrap",  1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 16'd0);

    // Cold taken branch: allocate 0x0010 -> 0x0040.
    fetch("cold_f", 16'h0010, 16'h0011, 1'b0, 16'd0);
    idle ("cold_i", 1'b0, 16'd0);
    step ("cold_res", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0040, 1'b1, 1'b1, 16'd0);
    idle ("cold_nop", 1'b1, 16'd1);
    fetch("cold_ref", 16'h0010, 16'h0040, 1'b0, 16'd1);
    idle ("cold_i2", 1'b0, 16'd1);
    step ("cold_ok", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0001, 1'b0, 1'b0, 16'd1);

    // Counter hysteresis: 11 -> 11 -> 10 -> 01.
    fetch("hy_f1", 16'h0010, 16'h0040, 1'b0, 16'd1);
    idle ("hy_i1", 1'b0, 16'd1);
    step ("hy_t", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0001, 1'b0, 1'b0, 16'd1);
    fetch("hy_f2", 16'h0010, 16'h0040, 1'b0, 16'd1);
    idle ("hy_i2", 1'b0, 16'd1);
    step ("hy_nt1", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b1, 16'd1);
    idle ("hy_nop1", 1'b1, 16'd2);
    fetch("hy_f3", 16'h0010, 16'h0040, 1'b0, 16'd2);
    idle ("hy_i3", 1'b0, 16'd2);
    step ("hy_nt2", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b1, 16'd2);
    idle ("hy_nop2", 1'b1, 16'd3);
    fetch("hy_weak", 16'h0010, 16'h0011, 1'b0, 16'd3);

    // Alias: same index, different tag.
    fetch("alias_f", 16'h0050, 16'h0051, 1'b0, 16'd3);
    step ("alias_r1", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'd3);
    idle ("alias_r2", 1'b0, 16'd3);

    // Non-branch aliasing a taken entry at index 3.
    fetch("nb_f", 16'h0123, 16'h0124, 1'b0, 16'd3);
    idle ("nb_i", 1'b0, 16'd3);
    step ("nb_alloc", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h0200, 1'b1, 1'b1, 16'd3);
    idle ("nb_nop", 1'b1, 16'd4);
    fetch("nb_hit", 16'h0123, 16'h0200, 1'b0, 16'd4);
    idle ("nb_i2", 1'b0, 16'd4);
    step ("nb_res", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0124, 1'b1, 1'b1, 16'd4);
    idle ("nb_nop2", 1'b1, 16'd5);
    fetch("nb_inval", 16'h0123, 16'h0124, 1'b0, 16'd5);
    idle ("nb_i3", 1'b0, 16'd5);
    idle ("nb_r3", 1'b0, 16'd5);

    // Same-index update and lookup.
    fetch("si_f", 16'h0123, 16'h0124, 1'b0, 16'd5);
    idle ("si_i", 1'b0, 16'd5);
    step ("si_alloc", 1'b1, 16'h0123, 1'b1, 1'b1, 16'h0300, 16'h0300, 1'b1, 1'b1, 16'd5);
    fetch("si_new", 16'h0123, 16'h0300, 1'b1, 16'd6);
    fetch("si_a", 16'h0123, 16'h0300, 1'b0, 16'd6);
    idle ("si_i2", 1'b0, 16'd6);
    step ("si_same", 1'b1, 16'h0123, 1'b1, 1'b1, 16'h0300, 16'h0300, 1'b0, 1'b0, 16'd6);
    idle ("si_i3", 1'b0, 16'd6);
    step ("si_b_nt", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0124, 1'b1, 1'b1, 16'd6);
    // ctr went 10 -> 11 -> 10, so still predicted taken.
    fetch("si_ctr", 16'h0123, 16'h0300, 1'b1, 16'd7);

    // Reset asserted while nop_en is high.
    fetch("rf_f", 16'h0123, 16'h0300, 1'b0, 16'd7);
    idle ("rf_i", 1'b0, 16'd7);
    step ("rf_mis", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0124, 1'b1, 1'b1, 16'd7);
    idle ("rf_rst", 1'b1, 16'd8, 1'b1);
    fetch("rf_cold1", 16'h0123, 16'h0124, 1'b0, 16'd0);
    fetch("rf_cold2", 16'h0010, 16'h0011, 1'b0, 16'd0);
    idle ("rf_i2", 1'b0, 16'd0);
    idle ("rf_i3", 1'b0, 16'd0);

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_pred.md
BTB_PRED -- requirements
Module: btb_pred

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, address/data width; IDX_W, default 4, table index bits (depth 2^IDX_W); TAG_W, default 6, tag bits with IDX_W+TAG_W <= DATA_W; RES_DLY, default 2, fetch-to-resolve latency in cycles, >= 1.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
clk  in  1  clock
reset  in  1  synchronous active-high reset
f_valid  in  1  fetch slot valid this cycle
f_pc  in  DATA_W  fetch PC
r_is_branch  in  1  instruction at resolve stage is a branch
r_taken  in  1  actual branch outcome
r_target  in  DATA_W  actual branch target
next_pc  out  DATA_W  PC to fetch next cycle
redirect  out  1  mispredict detected this cycle
nop_en  out  1  kill in-flight wrong-path slots
miss_cnt  out  DATA_W  saturating mispredict count

Function
REQ-004 Table SHALL hold 2^IDX_W entries of {valid, tag[TAG_W], ctr[2], target[DATA_W]}.
REQ-005 Lookup index SHALL be f_pc[IDX_W-1:0]; tag SHALL be f_pc[IDX_W+TAG_W-1:IDX_W].
REQ-006 hit SHALL be valid AND tag equal; pred_taken SHALL be f_valid AND hit AND ctr[1]; lookup is combinational.
REQ-007 A delay line of RES_DLY stages SHALL carry {v, pc, pred_taken, pred_target, hit}; stage 0 captures v=f_valid when no redirect and nop_en=0.
REQ-008 Resolve inputs SHALL apply to the last stage only when its v=1; otherwise they are ignored.
REQ-009 Mispredict SHALL be: branch with r_taken != pred_taken; branch with r_taken=1, pred_taken=1, r_target != pred_target; or non-branch with pred_taken=1.
REQ-010 next_pc SHALL be, in priority order: on mispredict, r_target if r_taken, else resolved pc+1; if pred_taken, the table target; else f_pc+1.
REQ-011 All PC adds SHALL be modulo 2^DATA_W.
REQ-012 redirect SHALL equal mispredict, combinationally.
REQ-013 On mispredict, all delay-line v bits SHALL clear at the next edge, and the same-cycle fetch SHALL NOT be captured.
REQ-014 A flush counter SHALL load RES_DLY-1 on mispredict and decrement to 0.
REQ-015 nop_en SHALL be high in the mispredict cycle and while the flush counter is nonzero, giving RES_DLY cycles total.
REQ-016 Table update SHALL occur at the edge after a valid resolve.
REQ-017 Branch hit: ctr SHALL saturating-increment if taken and saturating-decrement if not; target SHALL be written if taken.
REQ-018 Branch miss, taken: the entry SHALL be allocated (overwrite) with valid=1, tag, ctr=2'b10, target.
REQ-019 Branch miss, not taken: the table SHALL NOT be changed.
REQ-020 Non-branch with hit: the entry valid bit SHALL clear.
REQ-021 A lookup and an update at the same index in the same cycle SHALL see the pre-update contents.
REQ-022 miss_cnt SHALL increment on each mispredict and saturate at all-ones.

Reset
REQ-023 Reset SHALL clear all valid bits, set every ctr to 2'b01, clear all delay-line v bits, the flush counter and miss_cnt; tags and targets need not be reset.
REQ-024 In the cycle after reset: redirect=0, nop_en=0, miss_cnt=0, next_pc=f_pc+1.
REQ-025 Reset SHALL override any in-progress flush or update in the same cycle.

Verification (DATA_W=16, IDX_W=4, TAG_W=6, RES_DLY=2)
REQ-026 Cold taken branch: fetch 0x0010 at t; at t+2 r_is_branch=1, r_taken=1, r_target=0x0040 -> redirect=1, next_pc=0x0040, nop_en high t+2..t+3, miss_cnt=1; refetch 0x0010 -> pred_taken, next_pc=0x0040, no redirect.
REQ-027 Counter hysteresis: allocate 0x0010 (ctr 10); resolve taken, taken (ctr 11), not taken (10), not taken (01) -> next fetch of 0x0010 gives next_pc=0x0011.
REQ-028 Alias: with 0x0010 allocated, fetch 0x0050 (same index, different tag) -> no hit, next_pc=0x0051.
REQ-029 BTB alias on a non-branch: allocated entry hit; at resolve r_is_branch=0 -> redirect, next_pc=pc+1, entry invalidated, miss_cnt increments.
REQ-030 Reset asserted during nop_en -> next cycle nop_en=0, miss_cnt=0, refetch of a trained PC misses.
REQ-031 Same-index update and lookup in one cycle -> lookup returns the old target/ctr; the following cycle returns the new values.
